// File: rtl/core_op_responder.sv
// Responder for the core op/in/out handshake: ifmap load into external SRAM, origin/depth tracking, 2x2 display.
// Latency: op_ready two cycles after the cycle an op is presented; display data one cycle after each SRAM read.
// Backpressure: in_ready is held high only in LOAD; ops outside WAIT are ignored; display streams without stalls.
module core_op_responder #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 14,
    parameter int IMG_W  = 8,
    parameter int CH_MAX = 32,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_op_valid,
    input  logic [3:0]        i_op_mode,
    output logic              o_op_ready,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_out_valid,
    output logic [OUT_W-1:0]  o_out_data,
    output logic              o_mem_cen,
    output logic              o_mem_wen,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);
    localparam int XY_W  = $clog2(IMG_W);
    localparam int CH_W  = $clog2(CH_MAX);
    localparam int DEP_W = CH_W + 1;
    localparam int RD_W  = CH_W + 2;

    localparam logic [XY_W-1:0]   XY_MAX    = XY_W'(IMG_W - 2);
    localparam logic [DEP_W-1:0]  DEP_MIN   = DEP_W'(8);
    localparam logic [DEP_W-1:0]  DEP_MAX   = DEP_W'(CH_MAX);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_W * CH_MAX - 1);

    // CMD is the decode cycle between capture and completion; it is where modes 1-6 commit.
    typedef enum logic [2:0] {
        S_RDY, S_WAIT, S_CMD, S_LOAD, S_DISP, S_DRAIN
    } state_t;

    state_t            state, state_d;
    logic              live;
    logic [3:0]        mode_q;
    logic [XY_W-1:0]   x_q, y_q;
    logic [DEP_W-1:0]  dep_q;
    logic [ADDR_W-1:0] ld_cnt;
    logic [RD_W-1:0]   rd_cnt;
    logic              out_vld_q;

    logic              ld_fire;
    logic [RD_W-1:0]   rd_last;
    logic [DEP_W+1:0]  rd_total;
    logic [XY_W-1:0]   rd_row, rd_col;
    logic [ADDR_W-1:0] rd_addr;

    // Origin and depth only move in CMD, so they stay frozen for the whole display.
    assign rd_total = {dep_q, 2'b00};
    assign rd_last  = RD_W'(rd_total - 1'b1);
    assign rd_row   = y_q + XY_W'(rd_cnt[1]);
    assign rd_col   = x_q + XY_W'(rd_cnt[0]);
    assign rd_addr  = ADDR_W'({rd_cnt[RD_W-1:2], rd_row, rd_col});
    assign ld_fire  = (state == S_LOAD) && i_in_valid;

    assign o_out_valid = out_vld_q;
    assign o_out_data  = out_vld_q ? OUT_W'(i_mem_rdata) : '0;

    always_comb begin
        state_d     = state;
        o_op_ready  = 1'b0;
        o_in_ready  = 1'b0;
        o_mem_cen   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        case (state)
            // live keeps op_ready low until the first edge after reset release.
            S_RDY: begin
                o_op_ready = live;
                if (live) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_op_valid) state_d = S_CMD;
            end
            S_CMD: begin
                case (mode_q)
                    4'd0:    state_d = S_LOAD;
                    4'd7:    state_d = S_DISP;
                    default: state_d = S_RDY;
                endcase
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    o_mem_cen   = 1'b1;
                    o_mem_wen   = 1'b1;
                    o_mem_addr  = ld_cnt;
                    o_mem_wdata = i_in_data;
                    if (ld_cnt == LAST_ADDR) state_d = S_RDY;
                end
            end
            S_DISP: begin
                o_mem_cen  = 1'b1;
                o_mem_addr = rd_addr;
                if (rd_cnt == rd_last) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_RDY;
            default: state_d = S_RDY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RDY;
            live      <= 1'b0;
            mode_q    <= '0;
            x_q       <= '0;
            y_q       <= '0;
            dep_q     <= DEP_MAX;
            ld_cnt    <= '0;
            rd_cnt    <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state     <= state_d;
            live      <= 1'b1;
            out_vld_q <= (state == S_DISP);
            if (state == S_WAIT && i_op_valid) mode_q <= i_op_mode;
            if (state == S_CMD) begin
                case (mode_q)
                    4'd1: if (x_q < XY_MAX)    x_q   <= x_q + 1'b1;
                    4'd2: if (x_q != '0)       x_q   <= x_q - 1'b1;
                    4'd3: if (y_q != '0)       y_q   <= y_q - 1'b1;
                    4'd4: if (y_q < XY_MAX)    y_q   <= y_q + 1'b1;
                    4'd5: if (dep_q > DEP_MIN) dep_q <= dep_q >> 1;
                    4'd6: if (dep_q < DEP_MAX) dep_q <= dep_q << 1;
                    default: ;
                endcase
            end
            if (ld_fire) ld_cnt <= (ld_cnt == LAST_ADDR) ? '0 : ld_cnt + 1'b1;
            rd_cnt <= (state == S_DISP) ? rd_cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_core_op_responder.sv
// Directed bench for core_op_responder: SRAM model, reference origin/depth model, protocol monitor.
module tb_core_op_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op_mode = '0;
    logic        op_ready;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [13:0] out_data;
    logic        mem_cen, mem_wen;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  sram [0:2047];
    int n_checks = 0, n_fail = 0;
    int cyc = 0, wr_cnt = 0, wr_addr_err = 0, out_cnt = 0, viol = 0;
    int wr_base = 0, err_base = 0, op_cyc = 0, rdy_lat = 0;
    logic prev_rdy = 1'b0;
    int outq[$];
    int mx = 0, my = 0, mdep = 32, pat = 0;

    core_op_responder dut (
        .clk(clk), .rst_n(rst_n),
        .i_op_valid(op_valid), .i_op_mode(op_mode), .o_op_ready(op_ready),
        .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
        .o_out_valid(out_valid), .o_out_data(out_data),
        .o_mem_cen(mem_cen), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_cen) begin
            if (mem_wen) sram[mem_addr] <= mem_wdata;
            else         mem_rdata <= sram[mem_addr];
        end
    end

    always @(negedge clk) begin
        if (mem_cen && mem_wen) begin
            if (int'(mem_addr) != wr_cnt - wr_base) wr_addr_err <= wr_addr_err + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (out_valid) begin
            outq.push_back(int'(out_data));
            out_cnt <= out_cnt + 1;
        end
        viol <= viol + int'(out_valid && (op_ready || in_valid || op_valid))
                     + int'(op_ready && (in_valid || op_valid))
                     + int'(op_ready && prev_rdy);
        prev_rdy <= op_ready;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pix(input int p, input int i);
        return (p == 0) ? (i % 256) : ((i * 5 + 3) % 256);
    endfunction

    function automatic int outs_bus();
        return int'(op_ready) + int'(in_ready) + int'(out_valid) + int'(mem_cen)
             + int'(mem_wen) + int'(|mem_addr) + int'(|mem_wdata) + int'(|out_data);
    endfunction

    task automatic model_update(input int m);
        case (m)
            1: if (mx < 6) mx++;
            2: if (mx > 0) mx--;
            3: if (my > 0) my--;
            4: if (my < 6) my++;
            5: if (mdep > 8) mdep = mdep / 2;
            6: if (mdep < 32) mdep = mdep * 2;
            default: ;
        endcase
    endtask

    task automatic wait_rdy(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            found = op_ready;
        end
        rdy_lat = cyc - op_cyc;
        if (!found) check({tag, "_rdy_timeout"}, 0, 1);
    endtask

    task automatic issue(input int m);
        @(posedge clk); #1;
        op_valid = 1'b1;
        op_mode  = 4'(m);
        op_cyc   = cyc;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op_mode  = '0;
    endtask

    task automatic do_op(input int m);
        issue(m);
        wait_rdy("op");
        model_update(m);
    endtask

    task automatic load_bytes(input int n, input int gmin, input int gmax, input int p);
        int g;
        bit acc;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = 8'(pix(p, i));
            acc = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
            if (!acc) begin
                check("load_accept_timeout", 0, 1);
                return;
            end
        end
    endtask

    task automatic full_load(input string tag, input int gmin, input int gmax, input int p);
        wr_base  = wr_cnt;
        err_base = wr_addr_err;
        pat = p;
        issue(0);
        load_bytes(2048, gmin, gmax, p);
        wait_rdy(tag);
        check({tag, "_writes"}, wr_cnt - wr_base, 2048);
        check({tag, "_addr_err"}, wr_addr_err - err_base, 0);
    endtask

    task automatic disp(input string tag);
        int errs, n, c, q, a;
        outq.delete();
        issue(7);
        wait_rdy(tag);
        n = 4 * mdep;
        check({tag, "_count"}, outq.size(), n);
        errs = 0;
        for (int k = 0; k < outq.size() && k < n; k++) begin
            c = k / 4;
            q = k % 4;
            a = c * 64 + (my + q / 2) * 8 + (mx + q % 2);
            if (outq[k] != pix(pat, a)) errs++;
        end
        check({tag, "_data"}, errs, 0);
    endtask

    initial begin
        int exp8[8];
        int exp4[4];
        int c0;
        exp8 = '{0, 1, 8, 9, 64, 65, 72, 73};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", outs_bus(), 0);
        rst_n = 1'b1;
        op_cyc = cyc;
        wait_rdy("rst");
        check("rst_first_rdy", rdy_lat, 1);

        full_load("load_a", 1, 5, 0);
        disp("disp0");
        for (int k = 0; k < 8; k++)
            if (k < outq.size()) check($sformatf("disp0_o%0d", k), outq[k], exp8[k]);
        for (int k = 0; k < 4; k++)
            if (16 + k < outq.size()) check($sformatf("disp0_g5_%0d", k), outq[16 + k], exp8[k]);

        repeat (8) do_op(1);
        repeat (8) do_op(4);
        check("clamp_x_hi", mx, 6);
        check("clamp_y_hi", my, 6);
        disp("disp66");
        exp4 = '{54, 55, 62, 63};
        for (int k = 0; k < 4; k++)
            if (k < outq.size()) check($sformatf("disp66_o%0d", k), outq[k], exp4[k]);
        repeat (9) do_op(2);
        repeat (9) do_op(3);
        disp("disp00");
        for (int k = 0; k < 4; k++)
            if (k < outq.size()) check($sformatf("disp00_o%0d", k), outq[k], exp8[k]);

        repeat (3) do_op(5);
        disp("dep8");
        check("dep8_n", outq.size(), 32);
        repeat (3) do_op(6);
        disp("dep32");
        check("dep32_n", outq.size(), 128);

        c0 = out_cnt;
        issue(9);
        wait_rdy("inv9");
        check("inv9_lat", rdy_lat, 2);
        issue(15);
        wait_rdy("inv15");
        check("inv15_lat", rdy_lat, 2);
        check("inv_no_out", out_cnt - c0, 0);
        disp("inv_disp");

        for (int k = 0; k < 24; k++) begin
            int m;
            m = $urandom_range(15, 1);
            repeat ($urandom_range(10, 1)) @(posedge clk);
            do_op(m);
        end
        disp("rand_disp");
        check("protocol_viol", viol, 0);

        issue(0);
        load_bytes(1000, 0, 2, 1);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", int'(in_ready), 0);
        repeat (3) @(negedge clk);
        check("abort_outputs", outs_bus(), 0);
        rst_n = 1'b1;
        op_cyc = cyc;
        wait_rdy("abort");
        check("abort_rdy_lat", rdy_lat, 1);
        mx = 0; my = 0; mdep = 32;
        full_load("load_b", 0, 2, 1);
        disp("disp_b");
        check("protocol_viol_end", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/core_op_responder.md
Name: core_op_responder

Overview:
- Responder end of the core's op/in/out handshake protocol, driven by the host-side stimulus sequencer.
- Issues op_ready, accepts op_valid/op_mode, and absorbs a 2048-byte ifmap load into an external 2048x8 SRAM.
- Tracks a 2x2 display origin and the channel depth.
- Streams display results on out_valid/out_data.
- Sits at the core boundary in front of the compute datapath.

Parameters:
- DATA_W, 8, input pixel width
- OUT_W, 14, out_data width; pixels are zero-extended
- IMG_W, 8, ifmap width and height in pixels
- CH_MAX, 32, maximum channel depth
- ADDR_W, 11, SRAM address width (IMG_W*IMG_W*CH_MAX = 2048 entries)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_op_valid  in  1  op_mode valid, 1-cycle pulse
- i_op_mode  in  4  operation code
- o_op_ready  out  1  1-cycle pulse: ready for next op
- i_in_valid  in  1  in_data valid
- i_in_data  in  DATA_W  ifmap byte
- o_in_ready  out  1  load byte accepted this cycle when also i_in_valid
- o_out_valid  out  1  out_data valid
- o_out_data  out  OUT_W  display pixel, zero-extended
- o_mem_cen  out  1  SRAM access enable
- o_mem_wen  out  1  1=write, 0=read
- o_mem_addr  out  ADDR_W  SRAM address
- o_mem_wdata  out  DATA_W  SRAM write data
- i_mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after read enable

Behaviour:
- Reset values:
  - All outputs 0.
  - Origin (x,y) = (0,0); depth = 32; load counter = 0; state = RDY.
- States: RDY, WAIT, LOAD, DISP, DRAIN.
- RDY:
  - o_op_ready=1 for exactly one cycle, then WAIT.
  - The first RDY cycle is the first posedge after rst_n deasserts.
- WAIT:
  - Idle until i_op_valid is sampled; latch i_op_mode.
  - i_op_valid in any state other than WAIT is ignored.
- Mode 0, load:
  - Enter LOAD. o_in_ready=1 throughout LOAD.
  - Each i_in_valid&&o_in_ready writes i_in_data to addr = counter; counter increments.
  - Address map: addr = c*64 + row*8 + col.
  - Gaps in i_in_valid are allowed; no byte is lost or duplicated.
  - After byte 2047 is written: o_in_ready drops the next cycle, counter clears, state goes to RDY.
- Mode 1: x = min(x+1, 6).
- Mode 2: x = max(x-1, 0).
- Mode 3: y = max(y-1, 0).
- Mode 4: y = min(y+1, 6).
- Mode 5: depth halves, floor 8 (32->16->8->8).
- Mode 6: depth doubles, ceiling 32 (8->16->32->32).
- Modes 1-6 update their register in the cycle after capture, then go to RDY.
- Clamped ops are legal no-ops that still complete through RDY.
- Mode 7, display:
  - DISP issues 4*depth reads, one per cycle.
  - Read order: for c = 0..depth-1: (y,x), (y,x+1), (y+1,x), (y+1,x+1).
  - Display origin/depth are frozen at capture.
  - o_out_valid follows each read by exactly 1 cycle, giving 4*depth consecutive valid cycles.
  - DRAIN covers the final read's data cycle. RDY is entered the cycle after the last o_out_valid.
- Modes 8-15: no state change; RDY next cycle.
- Mutual exclusion, guaranteed by construction:
  - o_out_valid never coincides with o_op_ready, i_in_valid or i_op_valid.
  - o_op_ready never coincides with i_in_valid or i_op_valid.
- SRAM:
  - o_mem_cen=1 only on the cycles that perform a write or read.
  - o_mem_wdata=0 when not writing.
- Reset mid-load or mid-display: all state aborts immediately, outputs go to 0, and RDY resumes after rst_n deasserts. SRAM contents are not cleared.

Test Plan:
- Load, then display at reset state:
  - Stimulus: load bytes d[i] = i mod 256 with random 1-5 cycle in_valid gaps, then op 7.
  - Required: exactly 2048 writes at addresses 0..2047.
  - Required: 128 outputs starting 0,1,8,9,64,65,72,73,128,...; 5th channel group = 0,1,8,9.
- Shift clamp:
  - Stimulus: op 1 x8, op 4 x8, then op 7.
  - Required: origin (6,6); first outputs 54,55,62,63.
  - Stimulus: op 2 x9 and op 3 x9 from there.
  - Required: back to (0,0).
- Depth clamp:
  - Stimulus: op 5 x3, then op 7.
  - Required: exactly 32 out_valid cycles.
  - Stimulus: op 6 x3, then op 7.
  - Required: 128 out_valid cycles.
- Invalid modes:
  - Stimulus: op 9, then op 15.
  - Required: each answered by an op_ready pulse 2 cycles after op_valid; origin and depth unchanged; no out_valid.
- Protocol checker:
  - Stimulus: random op sequence with 1-10 cycle op_valid delays.
  - Required: no forbidden overlap among the listed signal pairs.
  - Required: op_ready always a single-cycle pulse.
- Reset mid-load:
  - Stimulus: assert rst_n low after 1000 bytes.
  - Required: in_ready=0 immediately; op_ready pulse after release; a fresh 2048-byte load completes and displays correctly.
